// File: rtl/serial_shift_unit.sv
// serial_shift_unit: shared-chain SISO/SIPO shift register with saturating fill count; define SHIFT_PLOAD_EN to add parallel load (load, pdata)
module serial_shift_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             d,
`ifdef SHIFT_PLOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
`endif
  output logic             Q,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MAX = CW'(WIDTH);
  logic [CW-1:0] count;
  // advance the chain and the fill count; reset beats load, load beats shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      count <= '0;
    end
`ifdef SHIFT_PLOAD_EN
    else if (load) begin
      q     <= pdata;
      count <= MAX;
    end
`endif
    else if (shift_en) begin
      q     <= {q[WIDTH-2:0], d};
      count <= (count == MAX) ? count : count + 1'b1;
    end
  end
  assign Q    = q[WIDTH-1];
  assign full = (count == MAX);
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb_serial_shift_unit: directed and random checks of serial_shift_unit against a bit-history model
module tb_serial_shift_unit;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic shift_en = 1'b0;
  logic d = 1'b0;
  logic Q, full;
  logic [W-1:0] q;
`ifdef SHIFT_PLOAD_EN
  logic load = 1'b0;
  logic [W-1:0] pdata = '0;
`endif
  int vectors = 0;
  int miscompares = 0;
  bit hist[$];

  always #5 clk = ~clk;

  serial_shift_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .shift_en(shift_en),
    .d(d),
`ifdef SHIFT_PLOAD_EN
    .load(load),
    .pdata(pdata),
`endif
    .Q(Q),
    .q(q),
    .full(full)
  );

  function automatic logic [W-1:0] exp_q();
    logic [W-1:0] r = '0;
    for (int i = 0; i < hist.size(); i++) r[i] = hist[hist.size()-1-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic di, input logic l, input logic [W-1:0] pd);
    logic [W-1:0] eq;
    @(negedge clk);
    rst_n = r; shift_en = e; d = di;
`ifdef SHIFT_PLOAD_EN
    load = l; pdata = pd;
`endif
    @(posedge clk);
    #1;
    if (!r) hist.delete();
    else if (l) begin
      hist.delete();
      for (int i = W-1; i >= 0; i--) hist.push_back(pd[i]);
    end else if (e) begin
      hist.push_back(di);
      if (hist.size() > W) void'(hist.pop_front());
    end
    eq = exp_q();
    check("model_q", q, eq);
    check("model_Q", W'(Q), W'(eq[W-1]));
    check("model_full", W'(full), W'(hist.size() == W));
  endtask

  initial begin
    logic [W-1:0] fill_q [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    logic siso_q [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    check("reset_q", q, 4'b0000);
    check("reset_full", W'(full), '0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, (i % 2) == 0, 0, '0);
      check("fill_q", q, fill_q[i]);
      check("fill_full", W'(full), W'(i == 3));
    end
    check("fill_Q", W'(Q), W'(1));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, '0);
      check("siso_Q", W'(Q), W'(siso_q[i]));
      check("siso_full", W'(full), W'(1));
    end
    check("siso_q", q, 4'b0000);
    for (int i = 0; i < 4; i++) step(1, 1, (i % 2) == 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, i[0], 0, '0);
      check("hold_q", q, 4'b1010);
      check("hold_Q", W'(Q), W'(1));
    end
    step(0, 1, 1, 0, '0);
    check("midrst_q", q, 4'b0000);
    check("midrst_full", W'(full), '0);
    step(1, 1, 1, 0, '0);
    check("post_rst_q", q, 4'b0001);
`ifdef SHIFT_PLOAD_EN
    step(1, 1, 0, 1, 4'b1100);
    check("load_q", q, 4'b1100);
    check("load_full", W'(full), W'(1));
    step(1, 1, 1, 0, '0);
    check("load_shift_q", q, 4'b1001);
    check("load_shift_Q", W'(Q), W'(1));
`endif
    for (int i = 0; i < 400; i++) begin
      logic ld = 1'b0;
`ifdef SHIFT_PLOAD_EN
      ld = ($urandom_range(0, 7) == 0);
`endif
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 3) != 0, 1'($urandom), ld, W'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
